// File: rtl/prog_mem_reader_pkg.sv
// Shared definitions for the program-memory readback unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents: FSM state encodings and joystick line indices.
package prog_mem_reader_pkg;

  // Reader FSM state encodings
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH      = 3'd1;
  localparam logic [2:0] ST_WAIT       = 3'd2;
  localparam logic [2:0] ST_SHOW       = 3'd3;
  localparam logic [2:0] ST_AUTO_FETCH = 3'd4;
  localparam logic [2:0] ST_AUTO_WAIT  = 3'd5;
  localparam logic [2:0] ST_AUTO_HOLD  = 3'd6;

  // Bit positions of the joystick lines within stick_i
  localparam int STICK_AUTO = 0;
  localparam int STICK_HALF = 1;
  localparam int STICK_DEC  = 2;
  localparam int STICK_INC  = 3;

endpackage

// File: rtl/prog_mem_reader_stick_debounce.sv
// Debounces one raw active-low joystick line and emits a press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYC stable cycles to a level change; press is registered.
// Backpressure: none; the press pulse is one cycle wide and is not held.
//
// Ports:
//   clk_i    in   single clock, posedge
//   rst_i    in   asynchronous active-high reset
//   raw_i    in   raw line from the panel (active-low, asynchronous)
//   stable_o out  debounced level, 1 = released
//   press_o  out  one-cycle pulse on a debounced 1->0 transition
module stick_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // The panel line is asynchronous to clk_i; bring it in through two flops
  // before it is allowed to influence the counter. Resets to "released".
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Counter only runs while the synchronised level disagrees with the
  // accepted level; any bounce back to the accepted level restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        // Levels differ here, so a new low level means a 1->0 transition.
        press_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/prog_mem_reader.sv
// Front-panel readback of the program memory: joystick steps the address, LEDs show one half-word.
// Latency: press at N -> address at N+1, read strobe during N+1, word/LEDs valid from N+3.
// Backpressure: none; presses arriving while a read is in flight are dropped, not queued.
//
// Ports:
//   clk_i        in   single clock, posedge
//   rst_i        in   asynchronous active-high reset
//   en_i         in   reader active; low forces IDLE
//   stick_i      in   raw joystick, active-low: [0] auto, [1] half, [2] addr-1, [3] addr+1
//   mem_data_i   in   program word, valid the cycle after mem_rd_en_o
//   mem_addr_o   out  read address (the address register)
//   mem_rd_en_o  out  one-cycle read strobe
//   leds_o       out  displayed half of the captured word
//   addr_o       out  current address
//   half_o       out  0 = lower byte shown, 1 = upper bits shown
//   auto_o       out  auto-scan active
module prog_mem_reader
  import prog_mem_reader_pkg::*;
#(
  parameter int ADDR_W       = 7,
  parameter int WORD_W       = 13,
  parameter int DEBOUNCE_CYC = 16,
  parameter int HOLD_CYC     = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [3:0]        stick_i,
  input  logic [WORD_W-1:0] mem_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  output logic [7:0]        leds_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              half_o,
  output logic              auto_o
);

  // One counter spans both halves of an auto-scan hold period.
  localparam int HOLD_W = $clog2(2 * HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MID = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(2 * HOLD_CYC - 1);

  logic [3:0]        press;
  logic [3:0]        stick_lvl;
  logic              unused_stick_lvl;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] word_q;
  logic              half_q;
  logic              auto_q;
  logic              en_q;
  logic [HOLD_W-1:0] hold_cnt_q;

  logic              inc_only;
  logic              dec_only;

  for (genvar i = 0; i < 4; i++) begin : g_db
    stick_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (stick_i[i]),
      .stable_o(stick_lvl[i]),
      .press_o (press[i])
    );
  end

  // Only press edges drive the FSM; the debounced levels are not needed here.
  assign unused_stick_lvl = &stick_lvl;

  // Simultaneous inc and dec cancel each other.
  assign inc_only = press[STICK_INC] & ~press[STICK_DEC];
  assign dec_only = press[STICK_DEC] & ~press[STICK_INC];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      half_q     <= 1'b0;
      auto_q     <= 1'b0;
      en_q       <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      en_q <= en_i;
      if (!en_i) begin
        // Dropping enable abandons any read in flight; display state holds.
        state_q <= ST_IDLE;
        auto_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!en_q) state_q <= ST_FETCH;
          end
          ST_FETCH: state_q <= ST_WAIT;
          ST_WAIT: begin
            word_q  <= mem_data_i;
            state_q <= ST_SHOW;
          end
          ST_SHOW: begin
            if (press[STICK_AUTO]) begin
              auto_q  <= 1'b1;
              half_q  <= 1'b0;
              state_q <= ST_AUTO_FETCH;
            end else if (inc_only) begin
              addr_q  <= addr_q + ADDR_W'(1);
              half_q  <= 1'b0;
              state_q <= ST_FETCH;
            end else if (dec_only) begin
              addr_q  <= addr_q - ADDR_W'(1);
              half_q  <= 1'b0;
              state_q <= ST_FETCH;
            end else if (press[STICK_HALF]) begin
              half_q <= ~half_q;
            end
          end
          ST_AUTO_FETCH: state_q <= ST_AUTO_WAIT;
          ST_AUTO_WAIT: begin
            word_q     <= mem_data_i;
            hold_cnt_q <= '0;
            state_q    <= ST_AUTO_HOLD;
          end
          ST_AUTO_HOLD: begin
            if (press[STICK_AUTO]) begin
              auto_q  <= 1'b0;
              state_q <= ST_SHOW;
            end else if (hold_cnt_q == HOLD_END) begin
              addr_q  <= addr_q + ADDR_W'(1);
              half_q  <= 1'b0;
              state_q <= ST_AUTO_FETCH;
            end else begin
              // Switch to the upper half after the first HOLD_CYC cycles.
              if (hold_cnt_q == HOLD_MID) half_q <= 1'b1;
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Gated with en_i so a read is never issued in the cycle enable drops.
  assign mem_rd_en_o = en_i & ((state_q == ST_FETCH) | (state_q == ST_AUTO_FETCH));
  assign mem_addr_o  = addr_q;
  assign addr_o      = addr_q;
  assign half_o      = half_q;
  assign auto_o      = auto_q;
  assign leds_o      = half_q ? {{(16 - WORD_W){1'b0}}, word_q[WORD_W-1:8]} : word_q[7:0];

endmodule

// File: tb/tb_prog_mem_reader.sv
module tb_prog_mem_reader;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  stick;
  logic [12:0] mem_data;
  logic [6:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  leds;
  logic [6:0]  addr;
  logic        half;
  logic        auto_on;

  logic [12:0] mem [128];
  int          strobes = 0;
  int          s0;
  int          n_vec = 0;
  int          n_bad = 0;

  prog_mem_reader #(
    .ADDR_W      (7),
    .WORD_W      (13),
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .stick_i    (stick),
    .mem_data_i (mem_data),
    .mem_addr_o (mem_addr),
    .mem_rd_en_o(mem_rd_en),
    .leds_o     (leds),
    .addr_o     (addr),
    .half_o     (half),
    .auto_o     (auto_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: data only valid the cycle after a strobe, junk otherwise.
  always @(posedge clk) begin
    mem_data <= mem_rd_en ? mem[mem_addr] : 13'h1FFF;
    if (mem_rd_en) strobes <= strobes + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx);
    stick[idx] = 1'b0;
    tick(8);
    stick[idx] = 1'b1;
    tick(10);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 13'h1000 | 13'(i * 3);
    rst   = 1'b1;
    en    = 1'b0;
    stick = 4'hF;
    tick(3);

    // 1: reset values, then first fetch on enable
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_half", 32'(half), 32'h0);
    chk("rst_auto", 32'(auto_on), 32'h0);
    chk("rst_rden", 32'(mem_rd_en), 32'h0);
    s0  = strobes;
    rst = 1'b0;
    en  = 1'b1;
    tick(5);
    chk("en_strobes", 32'(strobes - s0), 32'd1);
    chk("en_leds", 32'(leds), 32'h00);
    chk("en_half", 32'(half), 32'h0);
    press(1);
    chk("half_leds", 32'(leds), 32'h10);
    chk("half_half", 32'(half), 32'h1);

    // 2: three increments, then a too-short glitch
    s0 = strobes;
    for (int i = 0; i < 3; i++) press(3);
    chk("inc3_addr", 32'(addr), 32'd3);
    chk("inc3_leds", 32'(leds), 32'h09);
    chk("inc3_half", 32'(half), 32'h0);
    chk("inc3_strobes", 32'(strobes - s0), 32'd3);
    stick[3] = 1'b0;
    tick(2);
    stick[3] = 1'b1;
    tick(10);
    chk("glitch_addr", 32'(addr), 32'd3);
    chk("glitch_strobes", 32'(strobes - s0), 32'd3);

    // 3: wrap in both directions
    for (int i = 0; i < 3; i++) press(2);
    chk("dec3_addr", 32'(addr), 32'd0);
    press(2);
    chk("wrap_dn_addr", 32'(addr), 32'd127);
    chk("wrap_dn_leds", 32'(leds), 32'h7D);
    press(3);
    chk("wrap_up_addr", 32'(addr), 32'd0);
    chk("wrap_up_leds", 32'(leds), 32'h00);

    // 4: inc+dec together cancel; inc during WAIT is dropped
    s0 = strobes;
    stick[3:2] = 2'b00;
    tick(8);
    stick[3:2] = 2'b11;
    tick(10);
    chk("both_addr", 32'(addr), 32'd0);
    chk("both_strobes", 32'(strobes - s0), 32'd0);
    s0 = strobes;
    stick[2] = 1'b0;
    tick(2);
    stick[3] = 1'b0;
    tick(8);
    stick[3:2] = 2'b11;
    tick(10);
    chk("wait_drop_addr", 32'(addr), 32'd127);
    chk("wait_drop_strobes", 32'(strobes - s0), 32'd1);
    chk("wait_drop_leds", 32'(leds), 32'h7D);

    // 5: auto-scan from 126 across the wrap
    press(2);
    chk("pre_auto_addr", 32'(addr), 32'd126);
    chk("pre_auto_leds", 32'(leds), 32'h7A);
    stick[0] = 1'b0;
    tick(7);
    chk("auto_on", 32'(auto_on), 32'h1);
    chk("auto_rden", 32'(mem_rd_en), 32'h1);
    chk("auto_addr0", 32'(addr), 32'd126);
    stick[0] = 1'b1;
    tick(3);
    chk("hold_lo_half", 32'(half), 32'h0);
    chk("hold_lo_leds", 32'(leds), 32'h7A);
    tick(6);
    chk("hold_lo_end", 32'(half), 32'h0);
    tick(1);
    chk("hold_hi_half", 32'(half), 32'h1);
    chk("hold_hi_leds", 32'(leds), 32'h11);
    tick(7);
    chk("hold_hi_end_half", 32'(half), 32'h1);
    chk("hold_hi_end_addr", 32'(addr), 32'd126);
    tick(1);
    chk("step_addr", 32'(addr), 32'd127);
    chk("step_half", 32'(half), 32'h0);
    tick(4);
    chk("step_leds", 32'(leds), 32'h7D);
    tick(14);
    chk("auto_wrap_addr", 32'(addr), 32'd0);
    tick(3);
    chk("auto_wrap_leds", 32'(leds), 32'h00);
    tick(2);
    stick[0] = 1'b0;
    tick(8);
    chk("auto_off", 32'(auto_on), 32'h0);
    chk("auto_off_addr", 32'(addr), 32'd0);
    chk("auto_off_half", 32'(half), 32'h1);
    chk("auto_off_leds", 32'(leds), 32'h10);
    stick[0] = 1'b1;
    tick(20);
    chk("show_held_addr", 32'(addr), 32'd0);
    chk("show_held_auto", 32'(auto_on), 32'h0);

    // 6: enable drop mid-FETCH, then reset mid-hold
    s0 = strobes;
    stick[3] = 1'b0;
    tick(7);
    en       = 1'b0;
    stick[3] = 1'b1;
    #1;
    chk("enlow_rden", 32'(mem_rd_en), 32'h0);
    tick(5);
    chk("enlow_leds", 32'(leds), 32'h00);
    chk("enlow_addr", 32'(addr), 32'd1);
    chk("enlow_strobes", 32'(strobes - s0), 32'd0);
    s0 = strobes;
    en = 1'b1;
    tick(5);
    chk("reen_leds", 32'(leds), 32'h03);
    chk("reen_strobes", 32'(strobes - s0), 32'd1);
    stick[0] = 1'b0;
    tick(7);
    stick[0] = 1'b1;
    tick(13);
    chk("pre_rst_half", 32'(half), 32'h1);
    chk("pre_rst_leds", 32'(leds), 32'h10);
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(addr), 32'h0);
    chk("mid_rst_leds", 32'(leds), 32'h0);
    chk("mid_rst_half", 32'(half), 32'h0);
    chk("mid_rst_auto", 32'(auto_on), 32'h0);
    chk("mid_rst_rden", 32'(mem_rd_en), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
